// File: rtl/neo_sndcomm.sv
// neo_sndcomm: 68k <-> Z80 sound mailbox.
//   Holds one command byte (68k -> Z80) and one reply byte (Z80 -> 68k), each with a pending flag.
//   Drives a Z80 NMI with a guaranteed minimum low time.
//   All access strobes are asynchronous. Each is resynchronised into CLK_24M, and the access is
//   acted on at its synced rising edge (end of access).
//
// Optional feature: define SNDCOMM_OVERRUN_EN to build the saturating command-overrun counter.
// Without it, OVR_CNT is tied to zero.
//
// Ports:
//   CLK_24M            sole clock
//   RESET              synchronous, active-high reset
//   nSDW, M68K_DIN     68k command write strobe (active low) and data
//   nSDRD, M68K_DOUT   68k reply read strobe (active low) and reply byte
//   nSDZRD, SDD_OUT    Z80 command read strobe (active low) and command byte
//   nSDZWR, SDD_IN     Z80 reply write strobe (active low) and data
//   nNMIEN, nNMIDIS    Z80 NMI enable / disable strobes (active low)
//   nNMI               NMI to the Z80 (active low)
//   CMD_PEND           command written, not yet read by the Z80
//   REPLY_PEND         reply written, not yet read by the 68k
//   OVR_CNT            command overrun count
module neo_sndcomm #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NMI_MIN_CYC = 4,
    parameter bit          NMI_EN_RST  = 1'b0
) (
    input  logic       CLK_24M,
    input  logic       RESET,
    input  logic       nSDW,
    input  logic [7:0] M68K_DIN,
    input  logic       nSDRD,
    output logic [7:0] M68K_DOUT,
    input  logic       nSDZRD,
    input  logic       nSDZWR,
    input  logic [7:0] SDD_IN,
    output logic [7:0] SDD_OUT,
    input  logic       nNMIEN,
    input  logic       nNMIDIS,
    output logic       nNMI,
    output logic       CMD_PEND,
    output logic       REPLY_PEND,
    output logic [3:0] OVR_CNT
);

    localparam int unsigned IdxSdw    = 0;
    localparam int unsigned IdxSdrd   = 1;
    localparam int unsigned IdxSdzrd  = 2;
    localparam int unsigned IdxSdzwr  = 3;
    localparam int unsigned IdxNmien  = 4;
    localparam int unsigned IdxNmidis = 5;

    localparam logic [3:0] NmiLoad = 4'(NMI_MIN_CYC - 1);

    // ------------------------------------------------------------------
    // Strobe synchronisers and rise detection
    // ------------------------------------------------------------------
    logic [5:0] strobeRaw;
    logic [5:0] syncQ [SYNC_STAGES];
    logic [5:0] syncS;
    logic [5:0] histQ;
    logic [5:0] armQ;
    logic [5:0] rise;
    // validQ[k] marks that sync stage k holds a real post-reset pin sample.
    logic [SYNC_STAGES-1:0] validQ;

    assign strobeRaw = {nNMIDIS, nNMIEN, nSDZWR, nSDZRD, nSDRD, nSDW};
    assign syncS     = syncQ[SYNC_STAGES-1];

    // A strobe is only armed once a real high sample reaches the synced output, so an access
    // that straddles reset never produces a commit when it is released.
    assign rise = syncS & ~histQ & armQ;

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                syncQ[i] <= '1;
            end
            histQ  <= '1;
            armQ   <= '0;
            validQ <= '0;
        end else begin
            syncQ[0] <= strobeRaw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                syncQ[i] <= syncQ[i-1];
            end
            histQ  <= syncS;
            armQ   <= armQ | ({6{validQ[SYNC_STAGES-1]}} & syncS);
            validQ <= {validQ[SYNC_STAGES-2:0], 1'b1};
        end
    end

    logic sdwRise, sdrdRise, sdzrdRise, sdzwrRise, nmienRise, nmidisRise;
    assign sdwRise    = rise[IdxSdw];
    assign sdrdRise   = rise[IdxSdrd];
    assign sdzrdRise  = rise[IdxSdzrd];
    assign sdzwrRise  = rise[IdxSdzwr];
    assign nmienRise  = rise[IdxNmien];
    assign nmidisRise = rise[IdxNmidis];

    // ------------------------------------------------------------------
    // Mailbox datapath
    // ------------------------------------------------------------------
    logic [7:0] cmdStageQ, cmdStageD;
    logic [7:0] replyStageQ, replyStageD;
    logic [7:0] cmdQ, cmdD;
    logic [7:0] replyQ, replyD;
    logic       cmdPendQ, cmdPendD;
    logic       replyPendQ, replyPendD;
    logic       nmiEnQ, nmiEnD;
    logic       nmiReqQ, nmiReqD;

    always_comb begin
        cmdStageD   = cmdStageQ;
        replyStageD = replyStageQ;
        cmdD        = cmdQ;
        replyD      = replyQ;
        cmdPendD    = cmdPendQ;
        replyPendD  = replyPendQ;
        nmiEnD      = nmiEnQ;
        nmiReqD     = nmiReqQ;

        // Staging follows the data bus for as long as the synced strobe is low, so the commit
        // takes the value seen on the last low cycle.
        if (!syncS[IdxSdw]) cmdStageD = M68K_DIN;
        if (!syncS[IdxSdzwr]) replyStageD = SDD_IN;

        // Reads are applied first so a coincident commit overrides them.
        if (sdzrdRise) begin
            cmdPendD = 1'b0;
            nmiReqD  = 1'b0;
        end
        if (sdwRise) begin
            cmdD     = cmdStageQ;
            cmdPendD = 1'b1;
            if (nmiEnQ) nmiReqD = 1'b1;
        end

        if (sdrdRise) replyPendD = 1'b0;
        if (sdzwrRise) begin
            replyD     = replyStageQ;
            replyPendD = 1'b1;
        end

        if (nmienRise) nmiEnD = 1'b1;
        if (nmidisRise) begin
            nmiEnD  = 1'b0;
            nmiReqD = 1'b0;
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            cmdStageQ   <= 8'h00;
            replyStageQ <= 8'h00;
            cmdQ        <= 8'h00;
            replyQ      <= 8'h00;
            cmdPendQ    <= 1'b0;
            replyPendQ  <= 1'b0;
            nmiEnQ      <= NMI_EN_RST;
            nmiReqQ     <= 1'b0;
        end else begin
            cmdStageQ   <= cmdStageD;
            replyStageQ <= replyStageD;
            cmdQ        <= cmdD;
            replyQ      <= replyD;
            cmdPendQ    <= cmdPendD;
            replyPendQ  <= replyPendD;
            nmiEnQ      <= nmiEnD;
            nmiReqQ     <= nmiReqD;
        end
    end

    assign SDD_OUT    = cmdQ;
    assign M68K_DOUT  = replyQ;
    assign CMD_PEND   = cmdPendQ;
    assign REPLY_PEND = replyPendQ;

    // ------------------------------------------------------------------
    // Overrun counter
    // ------------------------------------------------------------------
`ifdef SNDCOMM_OVERRUN_EN
    logic       overrun;
    logic [3:0] ovrCntQ, ovrCntD;

    assign overrun = sdwRise & cmdPendQ & ~sdzrdRise;

    always_comb begin
        ovrCntD = ovrCntQ;
        if (overrun) begin
            if (ovrCntQ != 4'hF) ovrCntD = ovrCntQ + 4'd1;
        end else if (sdzrdRise) begin
            ovrCntD = 4'h0;
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) ovrCntQ <= 4'h0;
        else       ovrCntQ <= ovrCntD;
    end

    assign OVR_CNT = ovrCntQ;
`else
    assign OVR_CNT = 4'h0;
`endif

    // ------------------------------------------------------------------
    // nNMI state machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StActive, StHold} nmiState_e;

    nmiState_e  stateQ, stateD;
    logic [3:0] nmiCntQ, nmiCntD;

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            stateQ  <= StIdle;
            nmiCntQ <= 4'h0;
        end else begin
            stateQ  <= stateD;
            nmiCntQ <= nmiCntD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        nmiCntD = nmiCntQ;
        unique case (stateQ)
            StIdle: begin
                if (nmiReqQ) begin
                    stateD  = StActive;
                    nmiCntD = NmiLoad;
                end
            end
            StActive: begin
                if (nmiCntQ != 4'h0) begin
                    nmiCntD = nmiCntQ - 4'd1;
                    // Early clear: keep nNMI low until the minimum time has elapsed.
                    if (!nmiReqQ) stateD = StHold;
                end else if (!nmiReqQ) begin
                    stateD = StIdle;
                end
            end
            StHold: begin
                if (nmiCntQ != 4'h0) nmiCntD = nmiCntQ - 4'd1;
                // A new request resumes ACTIVE on the running count, without a reload.
                if (nmiReqQ)               stateD = StActive;
                else if (nmiCntQ == 4'h0) stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        nNMI = (stateQ == StIdle);
    end

endmodule
